firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench
===========================================================

# firebird7_in_gate1_tessent_data_mux_ctrl

IJTAG-accessible controller that owns the select and override data of a `tessent_data_mux` instance in `firebird7_in_gate1`. A (DATA_WIDTH+1)-bit test data register (TDR) on the IJTAG network loads an override request bit and override data. A handover FSM switches the mux to IJTAG data only after the functional side reports idle, with settle windows on entry and exit and a wait timeout. The block sits beside the mux: it drives the mux select and IJTAG data inputs and captures the functional data for readback.

## Interface
Parameters:
- DATA_WIDTH, 3, width of the mux data path
- SETTLE_CYCLES, 4, settle window length on entry and exit (≥1)
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for func_idle (≥1)

Ports:
- ijtag_tck  in  1  sole clock; all state updates on rising edge
- ijtag_reset  in  1  synchronous, active-low reset
- ijtag_sel  in  1  TDR selected on the IJTAG network
- ijtag_ce  in  1  capture enable
- ijtag_se  in  1  shift enable
- ijtag_ue  in  1  update enable
- ijtag_si  in  1  scan in
- ijtag_so  out  1  scan out, = sr[0]
- functional_data_in  in  DATA_WIDTH  functional value, captured for readback
- func_idle  in  1  functional side quiescent, so a switch is safe
- ijtag_select  out  1  to mux ijtag_select
- ijtag_data_out  out  DATA_WIDTH  to mux ijtag_data_in
- override_active  out  1  override is settled and in force
- timeout_err  out  1  sticky wait-timeout flag

## Operation
- Registers: shift register sr[DATA_WIDTH:0]; update registers req and data_reg[DATA_WIDTH-1:0]; FSM state; counter cnt sized for max(SETTLE_CYCLES, TIMEOUT_CYCLES).
- TDR actions apply only when ijtag_sel=1. Priority when several enables are high: capture > shift > update.
  - Capture: sr <= {override_active, functional_data_in}.
  - Shift: sr <= {ijtag_si, sr[DATA_WIDTH:1]}. Scan is LSB-first out; the request bit is loaded last.
  - Update: req <= sr[DATA_WIDTH]; data_reg <= sr[DATA_WIDTH-1:0].
- ijtag_data_out = data_reg at all times. An update during ACTIVE changes the override data on the next cycle.
- FSM states and transitions:
  - IDLE: if req=1, go to WAIT_IDLE and set cnt=0.
  - WAIT_IDLE: if req=0, go to IDLE. Else if func_idle=1, go to SETTLE_ON and set cnt=0. Else if cnt=TIMEOUT_CYCLES-1, go to ERR. Else cnt++.
  - SETTLE_ON: ijtag_select=1. When cnt=SETTLE_CYCLES-1, go to ACTIVE; else cnt++. req=0 here goes to SETTLE_OFF with cnt=0.
  - ACTIVE: ijtag_select=1 and override_active=1. If req=0, go to SETTLE_OFF with cnt=0.
  - SETTLE_OFF: ijtag_select=0. When cnt=SETTLE_CYCLES-1, go to IDLE; else cnt++. req is ignored until IDLE is reached.
  - ERR: ijtag_select=0 and timeout_err=1. When req=0, go to IDLE, which clears timeout_err.
- func_idle is sampled only in WAIT_IDLE. Its deassertion during SETTLE_ON or ACTIVE has no effect.
- Outputs are registered, decoded from the next state, so they change on the same edge as the state.

## Timing
- Reset (ijtag_reset=0 at an edge): sr=0, req=0, data_reg=0, state=IDLE, cnt=0.
  - Outputs: ijtag_so=0, ijtag_select=0, ijtag_data_out=0, override_active=0, timeout_err=0.
  - Reset overrides every other input. Reset mid-override drops ijtag_select on that edge, with no exit settle.
- Update at edge U makes req visible at U+1. With func_idle=1 throughout:
  - WAIT_IDLE is entered at U+1.
  - ijtag_select rises at U+2.
  - override_active rises at U+2+SETTLE_CYCLES.
- Release update at edge R: ijtag_select and override_active fall at R+1; IDLE is reached at R+1+SETTLE_CYCLES.
- Timeout: ERR is entered TIMEOUT_CYCLES edges after WAIT_IDLE entry if func_idle stays 0.
- ijtag_so changes only on shift or capture edges.

## Test plan
- Reset, then shift 4 bits 1,0,1,1 (si order, DATA_WIDTH=3) and update → data_reg=3'b101, req=1. With func_idle=1: ijtag_select=1 at U+2, override_active=1 at U+6, ijtag_data_out=3'b101.
- Hold func_idle=0 for 10 cycles after the request, then raise it → state stays WAIT_IDLE, then ijtag_select=1 one edge after func_idle is sampled 1. timeout_err stays 0.
- Hold func_idle=0 for 255 cycles → timeout_err=1 and ijtag_select stays 0. Update req=0 → timeout_err=0 and state=IDLE.
- In ACTIVE, update req=0 → ijtag_select=0 at R+1. A new req=1 update at R+2 is ignored until IDLE at R+5; WAIT_IDLE is then entered at R+6.
- Capture with functional_data_in=3'b110 while ACTIVE, then shift out 4 bits → ijtag_so sequence 0,1,1,1 (data LSB-first, then the status bit).
- Drive ijtag_reset=0 for one edge while ACTIVE → every output is 0 on that edge. Enables with ijtag_sel=0 → no TDR change.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR plus handover FSM that owns select and override data of the
// tessent_data_mux in firebird7_in_gate1.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int unsigned DATA_WIDTH     = 3,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] functional_data_in,
  input  logic                  func_idle,
  output logic                  ijtag_select,
  output logic [DATA_WIDTH-1:0] ijtag_data_out,
  output logic                  override_active,
  output logic                  timeout_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_SETTLE_ON,
    ST_ACTIVE,
    ST_SETTLE_OFF,
    ST_ERR
  } state_e;

  logic [DATA_WIDTH:0]   sr_q, sr_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic                  ovr_q, ovr_d;
  logic                  terr_q, terr_d;

  // TDR: capture beats shift beats update
  always_comb begin
    sr_d   = sr_q;
    req_d  = req_q;
    data_d = data_q;
    if (ijtag_sel) begin
      if (ijtag_ce) begin
        sr_d = {ovr_q, functional_data_in};
      end else if (ijtag_se) begin
        sr_d = {ijtag_si, sr_q[DATA_WIDTH:1]};
      end else if (ijtag_ue) begin
        req_d  = sr_q[DATA_WIDTH];
        data_d = sr_q[DATA_WIDTH-1:0];
      end
    end
  end

  // Handover FSM; outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          state_d = ST_WAIT_IDLE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_IDLE: begin
        if (!req_q) begin
          state_d = ST_IDLE;
        end else if (func_idle) begin
          state_d = ST_SETTLE_ON;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE_ON: begin
        if (!req_q) begin
          state_d = ST_SETTLE_OFF;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!req_q) begin
          state_d = ST_SETTLE_OFF;
          cnt_d   = '0;
        end
      end
      ST_SETTLE_OFF: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        if (!req_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    sel_d  = (state_d == ST_SETTLE_ON) || (state_d == ST_ACTIVE);
    ovr_d  = (state_d == ST_ACTIVE);
    terr_d = (state_d == ST_ERR);
  end

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      sr_q    <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      ovr_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      req_q   <= req_d;
      data_q  <= data_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  assign ijtag_so        = sr_q[0];
  assign ijtag_select    = sel_q;
  assign ijtag_data_out  = data_q;
  assign override_active = ovr_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Scoreboard bench: expected outputs are queued against an edge index when
// stimulus is driven and compared on the falling edge after that edge.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  localparam int S_SO   = 0;
  localparam int S_SEL  = 1;
  localparam int S_DATA = 2;
  localparam int S_OVR  = 3;
  localparam int S_TERR = 4;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic       so;
  logic [2:0] fdata = 3'b000;
  logic       fidle = 1'b0;
  logic       msel;
  logic [2:0] mdata;
  logic       ovr;
  logic       terr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  firebird7_in_gate1_tessent_data_mux_ctrl dut (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdata),
    .func_idle          (fidle),
    .ijtag_select       (msel),
    .ijtag_data_out     (mdata),
    .override_active    (ovr),
    .timeout_err        (terr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] get_sig(input int s);
    case (s)
      S_SO:    get_sig = 8'(so);
      S_SEL:   get_sig = 8'(msel);
      S_DATA:  get_sig = 8'(mdata);
      S_OVR:   get_sig = 8'(ovr);
      default: get_sig = 8'(terr);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_val(sb[i].tag, get_sig(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int at, input int s, input int val, input string tag);
    exp_t e;
    e.at  = at;
    e.sig = s;
    e.val = 8'(val);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    sel = 1'b1; se = 1'b1; si = b;
    tick();
    sel = 1'b0; se = 1'b0; si = 1'b0;
  endtask

  // bits[0] is shifted first
  task automatic shift4(input logic [3:0] bits);
    for (int i = 0; i < 4; i++) shift_bit(bits[i]);
  endtask

  task automatic update();
    sel = 1'b1; ue = 1'b1;
    tick();
    sel = 1'b0; ue = 1'b0;
  endtask

  task automatic expect_all_zero(input int at, input string tag);
    expect_at(at, S_SO,   0, {tag, "_so"});
    expect_at(at, S_SEL,  0, {tag, "_sel"});
    expect_at(at, S_DATA, 0, {tag, "_data"});
    expect_at(at, S_OVR,  0, {tag, "_ovr"});
    expect_at(at, S_TERR, 0, {tag, "_terr"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int u, r, c, x;

    // reset
    rst_n = 1'b0;
    tick();
    tick();
    expect_all_zero(cyc, "rst");
    rst_n = 1'b1;
    fidle = 1'b1;

    // request entry with func_idle high
    shift4(4'b1101);
    update();
    u = cyc;
    expect_at(u,     S_DATA, 5, "on_data");
    expect_at(u + 1, S_SEL,  0, "on_sel_u1");
    expect_at(u + 2, S_SEL,  1, "on_sel_u2");
    expect_at(u + 5, S_OVR,  0, "on_ovr_u5");
    expect_at(u + 6, S_OVR,  1, "on_ovr_u6");
    repeat (8) tick();

    // capture while active and shift the result out
    fdata = 3'b110;
    sel = 1'b1; ce = 1'b1;
    tick();
    sel = 1'b0; ce = 1'b0;
    c = cyc;
    expect_at(c, S_SO, 0, "cap_so0");
    for (int i = 1; i <= 3; i++) begin
      shift_bit(1'b0);
      expect_at(c + i, S_SO, 1, "cap_so");
    end

    // enables without ijtag_sel do nothing
    ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b0;
    tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0;
    expect_at(cyc, S_SO,   1, "nosel_so");
    expect_at(cyc, S_DATA, 5, "nosel_data");
    expect_at(cyc, S_SEL,  1, "nosel_sel");

    // release, then an early re-request held off until IDLE
    shift4(4'b0110);
    update();
    r = cyc;
    expect_at(r,      S_DATA, 6, "rel_data");
    expect_at(r,      S_SEL,  1, "rel_sel_r0");
    expect_at(r + 1,  S_SEL,  0, "rel_sel_r1");
    expect_at(r + 1,  S_OVR,  0, "rel_ovr_r1");
    shift_bit(1'b1);
    update();
    expect_at(r + 2,  S_DATA, 3, "rereq_data");
    expect_at(r + 4,  S_SEL,  0, "rereq_sel_r4");
    expect_at(r + 6,  S_SEL,  0, "rereq_sel_r6");
    expect_at(r + 7,  S_SEL,  1, "rereq_sel_r7");
    expect_at(r + 11, S_OVR,  1, "rereq_ovr_r11");
    while (cyc < r + 12) tick();

    // reset mid-override drops everything on that edge
    rst_n = 1'b0;
    tick();
    x = cyc;
    rst_n = 1'b1;
    expect_all_zero(x, "rst_act");
    tick();

    // func_idle held low for 10 edges then raised
    fidle = 1'b0;
    shift4(4'b1100);
    update();
    u = cyc;
    expect_at(u,      S_DATA, 4, "dly_data");
    expect_at(u + 10, S_SEL,  0, "dly_sel_u10");
    expect_at(u + 11, S_SEL,  1, "dly_sel_u11");
    expect_at(u + 11, S_TERR, 0, "dly_terr");
    expect_at(u + 15, S_OVR,  1, "dly_ovr");
    repeat (10) tick();
    fidle = 1'b1;
    repeat (5) tick();
    shift4(4'b0000);
    update();
    repeat (7) tick();

    // wait timeout into ERR, func_idle ignored there, then clear
    fidle = 1'b0;
    shift4(4'b1101);
    update();
    u = cyc;
    expect_at(u + 100, S_SEL,  0, "to_sel_u100");
    expect_at(u + 255, S_TERR, 0, "to_terr_u255");
    expect_at(u + 256, S_TERR, 1, "to_terr_u256");
    expect_at(u + 256, S_SEL,  0, "to_sel_u256");
    expect_at(u + 262, S_SEL,  0, "to_sel_idle_ignored");
    expect_at(u + 262, S_TERR, 1, "to_terr_sticky");
    repeat (258) tick();
    fidle = 1'b1;
    repeat (4) tick();
    shift4(4'b0000);
    update();
    r = cyc;
    expect_at(r,     S_TERR, 1, "clr_terr_r0");
    expect_at(r + 1, S_TERR, 0, "clr_terr_r1");
    expect_at(r + 2, S_SEL,  0, "clr_sel_r2");
    repeat (4) tick();

    @(negedge clk);
    check_val("sb_drain", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
